buffer_pipe: RTL and testbench
==============================

Name: buffer_pipe

Overview:
Parametrised, clocked successor to the single-bit combinational buffer gate: a WIDTH-bit, DEPTH-stage registered buffer line with per-stage valid tracking, stall, flush and occupancy count. Used in the shifting-register datapath and testbenches to insert a deterministic, cycle-exact delay on multi-bit buses instead of an `#delay` assign. Optional rising-edge activity counter on the output supports the team's power-estimation flow.

Parameters:
WIDTH, 4, data bits per stage; legal range ≥1.
DEPTH, 3, number of register stages (latency in cycles); legal range ≥1.
CNT_W, 16, width of the activity counter, used only with PWR_CNT_EN.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data qualifies for capture into stage 0
in_data  input  WIDTH  data into stage 0
stall  input  1  1 = hold all stages, no shift
flush  input  1  1 = synchronously clear all valid bits
out_valid  output  1  valid bit of stage DEPTH-1
out_data  output  WIDTH  data of stage DEPTH-1
occupancy  output  $clog2(DEPTH+1)  number of stages whose valid bit is set
pwr_cnt  output  CNT_W  output activity count; present only with PWR_CNT_EN

Behaviour:
- Reset: reset_n low asynchronously clears every stage's data and valid bits. While reset_n is low: out_valid=0, out_data=0, occupancy=0, pwr_cnt=0. Release is synchronous to the next clk edge with reset_n high.
- Shift (stall=0, flush=0) on each clk edge:
  - stage0 captures {in_valid, in_data}.
  - stage k captures stage k-1 for k=1..DEPTH-1.
  - Data is captured even when in_valid=0; bubbles propagate as valid=0.
- Latency: a word presented in cycle n appears on out_data/out_valid after the clk edge that ends cycle n+DEPTH-1, i.e. exactly DEPTH edges later when no stall occurs.
- Stall (stall=1, flush=0): all stage data and valid bits hold. in_data is dropped; the upstream block must hold its word.
- Flush (flush=1): on the clk edge, all valid bits clear. Data registers are don't-care but must not change, to avoid spurious toggles.
  - flush overrides stall.
  - in_valid during a flush cycle is discarded.
- occupancy: combinational popcount of the stage valid bits. Range 0..DEPTH; never exceeds DEPTH.
- Outputs are direct register outputs; there is no combinational path from any input to out_data or out_valid.
- DEPTH=1: single register stage; occupancy width is 1 bit.
- reset_n asserted mid-stream: all in-flight words are lost immediately, without waiting for a clock edge.

Optional Feature:
Macro BUFFER_PWR_CNT_EN.
- Defined: pwr_cnt port exists.
  - Each clk edge adds the count of out_data bits that transition 0→1 on that edge, matching the gate-library posedge-out convention.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
  - The counter is cleared only by reset_n; flush does not clear it.
- Not defined: no pwr_cnt port and no counter logic.
- Datapath behaviour is identical in both builds.

Test Plan:
- Reset: WIDTH=4, DEPTH=3; drive in_data=4'hF with in_valid=1 and hold reset_n=0 for 5 edges -> out_valid=0, out_data=0, occupancy=0 throughout; drop reset_n asynchronously mid-cycle -> outputs are 0 before the next edge.
- Latency: release reset, stream 4'h1,4'h2,4'h3,4'h4 with in_valid=1 -> out_data=4'h1 with out_valid=1 exactly 3 edges after the first capture; occupancy goes 1,2,3,3.
- Stall: fill with 4'hA,4'hB,4'hC, then stall=1 for 4 edges while in_data=4'h5 -> out_data holds 4'hA and occupancy holds 3; release stall -> next outputs are 4'hB, 4'hC, then 4'h5 only if it was re-presented.
- Flush over stall: pipeline holds 3 valid words; assert flush=1 and stall=1 together for one edge -> occupancy=0 and out_valid=0 next cycle; out_data is unchanged.
- Bubbles: in_valid pattern 1,0,1 with data 4'h3,4'h7,4'h9 -> out_valid pattern 1,0,1 with out_data 4'h3,4'h7,4'h9 starting 3 edges later; occupancy peaks at 2.
- BUFFER_PWR_CNT_EN, CNT_W=4: out_data sequence 4'h0→4'hF→4'h0→4'hF → pwr_cnt=4 then 8; drive further 0→F patterns until pwr_cnt saturates at 15 and stays there; assert flush -> pwr_cnt unchanged.

Source files
------------

// File: rtl/buffer_pipe.sv
// buffer_pipe: WIDTH-bit, DEPTH-stage registered delay line with per-stage valid, stall, flush
// and occupancy. Define BUFFER_PWR_CNT_EN to add the saturating output rising-edge counter.
module buffer_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 3
`ifdef BUFFER_PWR_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef BUFFER_PWR_CNT_EN
  ,
  output logic [CNT_W-1:0]           pwr_cnt
`endif
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic             shift_en;

  assign shift_en = !stall && !flush;

  // Flush clears only the valid bits; data is left alone to avoid spurious toggles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (!stall) begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OccW'(valid_q[k]);
    end
  end

`ifdef BUFFER_PWR_CNT_EN
  localparam int unsigned RiseW = $clog2(WIDTH + 1);
  localparam int unsigned SumW  = CNT_W + RiseW;

  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] rise;
  logic [RiseW-1:0] rise_cnt;
  logic [SumW-1:0]  sum;
  logic [CNT_W-1:0] cnt_max;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Value the last stage will load on this edge when shifting.
  if (DEPTH == 1) begin : g_nxt_in
    assign out_nxt = in_data;
  end else begin : g_nxt_stage
    assign out_nxt = data_q[DEPTH-2];
  end

  assign cnt_max = '1;

  always_comb begin
    rise     = shift_en ? (~data_q[DEPTH-1] & out_nxt) : '0;
    rise_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rise_cnt = rise_cnt + RiseW'(rise[i]);
    end
    sum   = SumW'(cnt_q) + SumW'(rise_cnt);
    cnt_d = (sum > SumW'(cnt_max)) ? cnt_max : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pwr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_buffer_pipe.sv
// Scoreboard bench for buffer_pipe (WIDTH=4, DEPTH=3); exercises the activity counter with
// CNT_W=4 when BUFFER_PWR_CNT_EN is defined.
module tb_buffer_pipe;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       stall;
  logic       flush;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] occupancy;
`ifdef BUFFER_PWR_CNT_EN
  logic [3:0] pwr_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  logic [3:0] exp_q [$];
  logic shifted = 1'b0;

  buffer_pipe #(
    .WIDTH(4),
    .DEPTH(3)
`ifdef BUFFER_PWR_CNT_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .stall    (stall),
    .flush    (flush),
    .out_valid(out_valid),
    .out_data (out_data),
    .occupancy(occupancy)
`ifdef BUFFER_PWR_CNT_EN
    ,
    .pwr_cnt  (pwr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A fresh output word exists only after an edge that actually shifted.
  always @(posedge clk) shifted = reset_n && !stall && !flush;

  always @(negedge clk) begin
    if (shifted && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("scoreboard_out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  // Called at a negedge: drives inputs, returns at the next negedge (one posedge later).
  task automatic cycle(input logic v, input logic [3:0] d, input logic st, input logic fl,
                       input logic push);
    in_valid = v;
    in_data  = d;
    stall    = st;
    flush    = fl;
    if (push) exp_q.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'hF;
    stall    = 1'b0;
    flush    = 1'b0;

    // Reset held across 5 edges with valid input present
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_occupancy", int'(occupancy), 0);
    end
    reset_n = 1'b1;

    // Latency: stream 1..4, occupancy 1,2,3,3; first word out after 3 edges
    cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
    check("lat_occ_e1", int'(occupancy), 1);
    cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
    check("lat_occ_e2", int'(occupancy), 2);
    check("lat_no_early_valid", int'(out_valid), 0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    check("lat_occ_e3", int'(occupancy), 3);
    check("lat_valid_e3", int'(out_valid), 1);
    check("lat_data_e3", int'(out_data), 1);
    cycle(1'b1, 4'h4, 1'b0, 1'b0, 1'b1);
    check("lat_occ_e4", int'(occupancy), 3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("lat_drained_occ", int'(occupancy), 0);
    check("lat_drained_valid", int'(out_valid), 0);

    // Stall: A,B,C loaded, stall 4 edges with 5 on the input (dropped)
    cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'hC, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
      check("stall_hold_data", int'(out_data), 'hA);
      check("stall_hold_occ", int'(occupancy), 3);
    end
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("stall_rel_data1", int'(out_data), 'hB);
    check("stall_rel_occ1", int'(occupancy), 2);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("stall_rel_data2", int'(out_data), 'hC);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("stall_5_dropped", int'(out_valid), 0);
    check("stall_rel_occ3", int'(occupancy), 0);

    // Flush overrides stall; in_valid during flush is discarded
    cycle(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    check("flush_pre_occ", int'(occupancy), 3);
    cycle(1'b1, 4'h9, 1'b1, 1'b1, 1'b0);
    check("flush_occ", int'(occupancy), 0);
    check("flush_valid", int'(out_valid), 0);
    check("flush_data_kept", int'(out_data), 6);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("flush_discard_occ", int'(occupancy), 0);

    // Bubbles: valid 1,0,1 with 3,7,9
    cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    check("bub_occ_e1", int'(occupancy), 1);
    cycle(1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
    check("bub_occ_e2", int'(occupancy), 1);
    cycle(1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
    check("bub_occ_peak", int'(occupancy), 2);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("bub_gap_valid", int'(out_valid), 0);
    check("bub_gap_data", int'(out_data), 7);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("bub_tail_valid", int'(out_valid), 1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle loses in-flight words at once
    cycle(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
    check("arst_pre_occ", int'(occupancy), 2);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_occ", int'(occupancy), 0);
    check("arst_valid", int'(out_valid), 0);
    check("arst_data", int'(out_data), 0);
`ifdef BUFFER_PWR_CNT_EN
    check("arst_pwr", int'(pwr_cnt), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

`ifdef BUFFER_PWR_CNT_EN
    // Output toggles 0->F every other edge from edge 3: +4 each, saturating at 15
    begin
      int rises = 0;
      int e;
      for (int i = 1; i <= 13; i++) begin
        if (i <= 10) cycle(1'b1, (i % 2 == 1) ? 4'hF : 4'h0, 1'b0, 1'b0, 1'b1);
        else cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        if (i >= 3 && i <= 11 && ((i - 3) % 2 == 0)) rises++;
        e = (rises * 4 > 15) ? 15 : rises * 4;
        check("pwr_cnt_seq", int'(pwr_cnt), e);
      end
      cycle(1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
      check("pwr_cnt_flush", int'(pwr_cnt), 15);
    end
`endif

    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
